// File: rtl/xadc_threshold_ctrl.sv
// Per-channel threshold monitor for XADC samples: capture, compare with hysteresis, write strobe.
// Optional XADC_DEBOUNCE_EN adds a per-channel saturating over-threshold counter before a flag may set.
module xadc_threshold_ctrl #(
    parameter int DATA_W = 12,
    parameter int UMB_W  = 8,
    parameter int NCH    = 4,
    parameter int DEB_N  = 3,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [UMB_W-1:0]  umbral_hi,
    input  logic [UMB_W-1:0]  umbral_lo,
    input  logic [DATA_W-1:0] Dato,
    input  logic [CH_W-1:0]   ch,
    // "new" is a reserved word, so the sample-available input is new_sample
    input  logic              new_sample,
    output logic [DATA_W-1:0] result,
    output logic [CH_W-1:0]   ch_out,
    output logic              WE2,
    output logic              rst_new,
    output logic [NCH-1:0]    flag,
    output logic              alarm_rise
);

    localparam int SH = DATA_W - UMB_W;

    if (UMB_W > DATA_W) begin : g_bad_umb_w
        $error("UMB_W must not exceed DATA_W");
    end
    if (DEB_N < 1) begin : g_bad_deb_n
        $error("DEB_N must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_WR, S_WAIT} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] hi_s, lo_s;
    logic              over, under, ch_ok, cur_flag, set_ok;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (new_sample) state_nx = S_CMP;
            S_CMP:  state_nx = S_WR;
            S_WR:   state_nx = S_WAIT;
            S_WAIT: if (!new_sample) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            ch_out <= '0;
        end else if (state == S_IDLE && new_sample) begin
            result <= Dato;
            ch_out <= ch;
        end
    end

    // Thresholds are live inputs but only matter while in CMP.
    always_comb begin
        hi_s     = DATA_W'(umbral_hi) << SH;
        lo_s     = DATA_W'(umbral_lo) << SH;
        over     = result > hi_s;
        under    = result < lo_s;
        ch_ok    = ({1'b0, ch_out} < (CH_W+1)'(NCH));
        cur_flag = ch_ok ? flag[ch_out] : 1'b0;
    end

`ifdef XADC_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_N + 1);
    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] cnt_cur, cnt_nx;

    always_comb begin
        cnt_cur = ch_ok ? cnt[ch_out] : '0;
        cnt_nx  = '0;
        if (over) cnt_nx = (cnt_cur == CNT_W'(DEB_N)) ? cnt_cur : cnt_cur + 1'b1;
        set_ok  = over && (cnt_nx == CNT_W'(DEB_N));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (state == S_CMP && ch_ok) begin
            cnt[ch_out] <= cnt_nx;
        end
    end
`else
    always_comb set_ok = over;
`endif

    // Strobes are registered on the CMP->WR edge so they are high exactly in WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag       <= '0;
            WE2        <= 1'b0;
            rst_new    <= 1'b0;
            alarm_rise <= 1'b0;
        end else begin
            WE2        <= 1'b0;
            rst_new    <= 1'b0;
            alarm_rise <= 1'b0;
            if (state == S_CMP) begin
                WE2     <= 1'b1;
                rst_new <= 1'b1;
                if (ch_ok) begin
                    if (set_ok) begin
                        flag[ch_out] <= 1'b1;
                        alarm_rise   <= !cur_flag;
                    end else if (under) begin
                        flag[ch_out] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xadc_threshold_ctrl.sv
// Bench for xadc_threshold_ctrl: directed scenarios plus random samples against a rule-level model.
module tb_xadc_threshold_ctrl;

    localparam int DEB_N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  umbral_hi, umbral_lo;
    logic [11:0] dato;
    logic [1:0]  ch;
    logic        new_sample;
    logic [11:0] result;
    logic [1:0]  ch_out;
    logic        we2, rst_new, alarm_rise;
    logic [3:0]  flag;

    int total = 0;
    int bad   = 0;

    logic [3:0] m_flag;
    int         m_cnt [4];
    int         pulses;
    logic       seen_alarm;

    always #5 clk = ~clk;

    xadc_threshold_ctrl #(.DATA_W(12), .UMB_W(8), .NCH(4), .DEB_N(DEB_N)) dut (
        .clk(clk), .rst(rst), .umbral_hi(umbral_hi), .umbral_lo(umbral_lo),
        .Dato(dato), .ch(ch), .new_sample(new_sample), .result(result),
        .ch_out(ch_out), .WE2(we2), .rst_new(rst_new), .flag(flag),
        .alarm_rise(alarm_rise)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flag = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Rule-level model: strict compares on scaled thresholds, set beats clear.
    task automatic model(input logic [11:0] d, input int c, input logic [7:0] hi,
                         input logic [7:0] lo, output logic exp_alarm);
        int  hi_v, lo_v;
        bit  over, under, set;
        hi_v = int'(hi) * 16;
        lo_v = int'(lo) * 16;
        over  = int'(d) > hi_v;
        under = int'(d) < lo_v;
`ifdef XADC_DEBOUNCE_EN
        if (over) m_cnt[c] = (m_cnt[c] < DEB_N) ? m_cnt[c] + 1 : DEB_N;
        else      m_cnt[c] = 0;
        set = over && (m_cnt[c] == DEB_N);
`else
        set = over;
`endif
        exp_alarm = 1'b0;
        if (set) begin
            exp_alarm = !m_flag[c];
            m_flag[c] = 1'b1;
        end else if (under) begin
            m_flag[c] = 1'b0;
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns there with the DUT idle.
    task automatic send(input logic [11:0] d, input logic [1:0] c,
                        input logic [7:0] hi, input logic [7:0] lo);
        logic ea;
        dato = d; ch = c; umbral_hi = hi; umbral_lo = lo; new_sample = 1'b1;
        @(posedge clk); #1;
        check("cmp_we2", we2, 0);
        check("cmp_alarm", alarm_rise, 0);
        @(posedge clk); #1;
        model(d, int'(c), hi, lo, ea);
        check("wr_we2", we2, 1);
        check("wr_rst_new", rst_new, 1);
        check("wr_result", result, d);
        check("wr_ch_out", ch_out, c);
        check("wr_flag", flag, m_flag);
        check("wr_alarm", alarm_rise, ea);
        seen_alarm = alarm_rise;
        new_sample = 1'b0;
        umbral_hi = 8'($urandom); umbral_lo = 8'($urandom); dato = 12'($urandom);
        @(posedge clk); #1;
        check("wait_we2", we2, 0);
        check("wait_alarm", alarm_rise, 0);
        check("wait_flag", flag, m_flag);
        @(posedge clk); #1;
    endtask

    initial begin
        logic ea;
        model_reset();
        seen_alarm = 1'b0;

        // Reset held with new asserted
        rst = 1'b1; new_sample = 1'b1; dato = 12'hABC; ch = 2'd3;
        umbral_hi = 8'h80; umbral_lo = 8'h60;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_ch_out", ch_out, 0);
        check("rst_we2", we2, 0);
        check("rst_rst_new", rst_new, 0);
        check("rst_flag", flag, 0);
        check("rst_alarm", alarm_rise, 0);
        rst = 1'b0; new_sample = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_we2", we2, 0);
        end

        // Set on ch1
        send(12'h801, 2'd1, 8'h80, 8'h60);
`ifndef XADC_DEBOUNCE_EN
        check("set_flag", flag, 4'b0010);
        check("set_alarm", seen_alarm, 1);
`endif
        // Hysteresis and boundaries
        send(12'h800, 2'd1, 8'h80, 8'h60);
        send(12'h600, 2'd1, 8'h80, 8'h60);
`ifndef XADC_DEBOUNCE_EN
        check("hyst_hold", flag[1], 1);
`endif
        send(12'h5FF, 2'd1, 8'h80, 8'h60);
        check("hyst_clear", flag[1], 0);
        send(12'h800, 2'd0, 8'h80, 8'h60);
        check("equal_no_set", flag[0], 0);

        // Held new yields one write; a one-cycle drop permits another
        dato = 12'h700; ch = 2'd3; umbral_hi = 8'h80; umbral_lo = 8'h60;
        new_sample = 1'b1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (we2) begin pulses++; model(12'h700, 3, 8'h80, 8'h60, ea); end
        end
        check("held_pulses", pulses, 1);
        new_sample = 1'b0;
        @(posedge clk); #1;
        if (we2) pulses++;
        new_sample = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (we2) begin pulses++; model(12'h700, 3, 8'h80, 8'h60, ea); end
        end
        new_sample = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (we2) pulses++;
        end
        check("reassert_pulses", pulses, 2);
        check("handshake_flag", flag, m_flag);

        // Reset during CMP aborts the sample
        send(12'h900, 2'd0, 8'h10, 8'h08);
        dato = 12'hFFF; ch = 2'd2; umbral_hi = 8'h80; umbral_lo = 8'h60; new_sample = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check("abort_we2", we2, 0);
        check("abort_rst_new", rst_new, 0);
        check("abort_flag", flag, 0);
        check("abort_alarm", alarm_rise, 0);
        rst = 1'b0; new_sample = 1'b0;
        @(posedge clk); #1;
        check("abort_after_we2", we2, 0);

`ifdef XADC_DEBOUNCE_EN
        send(12'h900, 2'd2, 8'h80, 8'h60);
        check("deb_first", flag[2], 0);
        send(12'h900, 2'd2, 8'h80, 8'h60);
        check("deb_second", flag[2], 0);
        send(12'h900, 2'd2, 8'h80, 8'h60);
        check("deb_third", flag[2], 1);
        check("deb_alarm", seen_alarm, 1);
        send(12'h100, 2'd2, 8'h80, 8'h60);
        send(12'h900, 2'd2, 8'h80, 8'h60);
        send(12'h100, 2'd2, 8'h80, 8'h60);
        send(12'h900, 2'd2, 8'h80, 8'h60);
        check("deb_broken", flag[2], 0);
`endif

        // Random samples, thresholds biased near the data so both rules fire
        for (int n = 0; n < 60; n++) begin
            logic [7:0]  hi, lo;
            logic [11:0] d;
            hi = 8'($urandom_range(0, 255));
            lo = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) d = 12'({hi, 4'h0} + 12'($urandom_range(0, 2)) - 12'd1);
            else                           d = 12'($urandom_range(0, 4095));
            send(d, 2'($urandom_range(0, 3)), hi, lo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
